nn1_feature_loader: RTL and testbench



---
 rtl/nn1_pkg.sv | 15 +
 rtl/nn1_pix_binarize.sv | 15 +
 rtl/nn1_feature_loader.sv | 197 +++++++++++++++++++
 tb/tb_nn1_feature_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn1_pkg.sv
// Shared constants and loader state type for the layer-1 neuron feature front end.
package nn1_pkg;

  localparam int unsigned NN1_IMAGE_SIZE = 121;
  localparam int unsigned NN1_PIXEL_BIT  = 8;
  localparam int unsigned NN1_THRESH     = 128;
  localparam int unsigned NN1_IDX_W      = $clog2(NN1_IMAGE_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } loader_state_t;

endpackage

// File: rtl/nn1_pix_binarize.sv
// Combinational pixel binarizer: pix_bit = (pix_data >= THRESH), unsigned compare.
module nn1_pix_binarize #(
  parameter int unsigned PIXEL_BIT = 8,
  parameter int unsigned THRESH    = 128
) (
  input  logic [PIXEL_BIT-1:0] pix_data,
  output logic                 pix_bit
);

  // One extra bit so a threshold of 2**PIXEL_BIT (never set) compares correctly.
  localparam logic [PIXEL_BIT:0] THRESH_EXT = (PIXEL_BIT + 1)'(THRESH);

  assign pix_bit = ({1'b0, pix_data} >= THRESH_EXT);

endmodule

// File: rtl/nn1_feature_loader.sv
// Binarizes an 11x11 raster pixel stream into the packed layer-1 feature vector with valid/ready output.
// Optional shadow load buffer enabled by defining NN1_FEAT_DOUBLE_BUF_EN.
module nn1_feature_loader
  import nn1_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE = NN1_IMAGE_SIZE,
  parameter int unsigned PIXEL_BIT  = NN1_PIXEL_BIT,
  parameter int unsigned THRESH     = NN1_THRESH
) (
  input  logic                  clk3,
  input  logic                  reset2,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [PIXEL_BIT-1:0]  pix_data,
  output logic                  pix_ready,
  output logic                  feat_valid,
  input  logic                  feat_ready,
  output logic [IMAGE_SIZE-1:0] input_features,
  output logic                  frame_err
);

  localparam int unsigned      IDX_W    = $clog2(IMAGE_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMAGE_SIZE - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  loader_state_t         state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IMAGE_SIZE-1:0] feat_q;
  logic                  feat_valid_q;
  logic                  pix_ready_q;
  logic                  frame_err_q;

  logic                  pix_bit;
  logic                  pix_xfer;
  logic                  feat_hs;

  logic [IMAGE_SIZE-1:0] ld_bits_nxt;
  logic [IDX_W-1:0]      ld_idx_nxt;
  logic                  ld_start;
  logic                  ld_err;
  logic                  ld_done;

  nn1_pix_binarize #(
    .PIXEL_BIT (PIXEL_BIT),
    .THRESH    (THRESH)
  ) u_binarize (
    .pix_data (pix_data),
    .pix_bit  (pix_bit)
  );

  assign pix_xfer = pix_valid & pix_ready_q;
  assign feat_hs  = feat_valid_q & feat_ready;

  assign pix_ready      = pix_ready_q;
  assign feat_valid     = feat_valid_q;
  assign input_features = feat_q;
  assign frame_err      = frame_err_q;

  // Next contents of the primary buffer for a pixel taken in IDLE or LOAD.
  always_comb begin
    ld_bits_nxt = feat_q;
    ld_idx_nxt  = idx_q;
    ld_start    = 1'b0;
    ld_err      = 1'b0;
    ld_done     = 1'b0;
    if (pix_xfer && (state_q != HOLD)) begin
      if (pix_sof) begin
        ld_start       = 1'b1;
        ld_err         = (state_q == LOAD);
        ld_bits_nxt    = '0;
        ld_bits_nxt[0] = pix_bit;
        ld_idx_nxt     = ONE_IDX;
      end else if (state_q == LOAD) begin
        ld_bits_nxt[idx_q] = pix_bit;
        if (idx_q == LAST_IDX) begin
          ld_done    = 1'b1;
          ld_idx_nxt = '0;
        end else begin
          ld_idx_nxt = idx_q + ONE_IDX;
        end
      end
    end
  end

`ifdef NN1_FEAT_DOUBLE_BUF_EN
  logic [IMAGE_SIZE-1:0] sh_bits_q;
  logic [IMAGE_SIZE-1:0] sh_bits_nxt;
  logic [IDX_W-1:0]      sh_idx_q;
  logic [IDX_W-1:0]      sh_idx_nxt;
  logic                  sh_busy_q;
  logic                  sh_busy_nxt;
  logic                  sh_full_q;
  logic                  sh_done;
  logic                  sh_err;

  // Shadow buffer fills while the primary frame is held for the consumer.
  always_comb begin
    sh_bits_nxt = sh_bits_q;
    sh_idx_nxt  = sh_idx_q;
    sh_busy_nxt = sh_busy_q;
    sh_done     = 1'b0;
    sh_err      = 1'b0;
    if (pix_xfer && (state_q == HOLD)) begin
      if (pix_sof) begin
        sh_err         = sh_busy_q;
        sh_bits_nxt    = '0;
        sh_bits_nxt[0] = pix_bit;
        sh_idx_nxt     = ONE_IDX;
        sh_busy_nxt    = 1'b1;
      end else if (sh_busy_q) begin
        sh_bits_nxt[sh_idx_q] = pix_bit;
        if (sh_idx_q == LAST_IDX) begin
          sh_done     = 1'b1;
          sh_busy_nxt = 1'b0;
          sh_idx_nxt  = '0;
        end else begin
          sh_idx_nxt = sh_idx_q + ONE_IDX;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk3 or negedge reset2) begin
    if (!reset2) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      feat_q       <= '0;
      feat_valid_q <= 1'b0;
      pix_ready_q  <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef NN1_FEAT_DOUBLE_BUF_EN
      sh_bits_q    <= '0;
      sh_idx_q     <= '0;
      sh_busy_q    <= 1'b0;
      sh_full_q    <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE, LOAD: begin
          feat_q      <= ld_bits_nxt;
          idx_q       <= ld_idx_nxt;
          frame_err_q <= ld_err;
          pix_ready_q <= 1'b1;
          if (ld_done) begin
            state_q      <= HOLD;
            feat_valid_q <= 1'b1;
`ifndef NN1_FEAT_DOUBLE_BUF_EN
            pix_ready_q  <= 1'b0;
`endif
          end else if (ld_start) begin
            state_q <= LOAD;
          end
        end
        HOLD: begin
`ifdef NN1_FEAT_DOUBLE_BUF_EN
          sh_bits_q   <= sh_bits_nxt;
          sh_idx_q    <= sh_idx_nxt;
          sh_busy_q   <= sh_busy_nxt;
          frame_err_q <= sh_err;
          pix_ready_q <= 1'b1;
          if (feat_hs) begin
            if (sh_full_q || sh_done) begin
              feat_q    <= sh_bits_nxt;
              sh_full_q <= 1'b0;
            end else if (sh_busy_nxt) begin
              // Partial shadow frame becomes the primary frame and keeps loading in LOAD.
              feat_q       <= sh_bits_nxt;
              idx_q        <= sh_idx_nxt;
              sh_busy_q    <= 1'b0;
              feat_valid_q <= 1'b0;
              state_q      <= LOAD;
            end else begin
              feat_valid_q <= 1'b0;
              state_q      <= IDLE;
            end
          end else if (sh_done || sh_full_q) begin
            sh_full_q   <= 1'b1;
            pix_ready_q <= 1'b0;
          end
`else
          pix_ready_q <= feat_hs;
          if (feat_hs) begin
            feat_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn1_feature_loader.sv
// Self-checking bench for nn1_feature_loader: frame-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_nn1_feature_loader;
  import nn1_pkg::*;

  localparam int unsigned N = NN1_IMAGE_SIZE;
`ifdef NN1_FEAT_DOUBLE_BUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic         clk3       = 1'b0;
  logic         reset2     = 1'b1;
  logic         pix_valid  = 1'b0;
  logic         pix_sof    = 1'b0;
  logic [7:0]   pix_data   = '0;
  logic         feat_ready = 1'b0;
  logic         pix_ready;
  logic         feat_valid;
  logic         frame_err;
  logic [N-1:0] input_features;

  int n_checks   = 0;
  int n_fail     = 0;
  int err_pulses = 0;

  always #5 clk3 = ~clk3;

  nn1_feature_loader #(
    .IMAGE_SIZE (N),
    .PIXEL_BIT  (8),
    .THRESH     (128)
  ) dut (
    .clk3           (clk3),
    .reset2         (reset2),
    .pix_valid      (pix_valid),
    .pix_sof        (pix_sof),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .feat_valid     (feat_valid),
    .feat_ready     (feat_ready),
    .input_features (input_features),
    .frame_err      (frame_err)
  );

  // Frame-level model: a collecting frame, the frame offered downstream, and a waiting frame.
  logic [N-1:0] m_vis       = '0;
  logic [N-1:0] m_col       = '0;
  logic [N-1:0] m_wait_bits = '0;
  int           m_n         = 0;
  bit           m_valid     = 1'b0;
  bit           m_wait      = 1'b0;
  bit           m_ready     = 1'b0;
  bit           m_err       = 1'b0;
  bit           m_xfer, m_hs, m_b;

  always @(posedge clk3 or negedge reset2) begin
    if (!reset2) begin
      m_vis = '0; m_col = '0; m_wait_bits = '0; m_n = 0;
      m_valid = 1'b0; m_wait = 1'b0; m_ready = 1'b0; m_err = 1'b0;
    end else begin
      m_xfer = pix_valid && m_ready;
      m_hs   = m_valid && feat_ready;
      m_b    = (pix_data >= 8'd128);
      m_err  = 1'b0;
      if (m_xfer) begin
        if (pix_sof) begin
          m_err    = (m_n > 0);
          m_col    = '0;
          m_col[0] = m_b;
          m_n      = 1;
        end else if (m_n > 0) begin
          m_col[m_n] = m_b;
          m_n++;
          if (m_n == N) begin
            m_n = 0;
            if (m_valid) begin
              m_wait      = 1'b1;
              m_wait_bits = m_col;
            end else begin
              m_vis   = m_col;
              m_valid = 1'b1;
            end
          end
        end
      end
      if (m_hs) begin
        if (m_wait) begin
          m_vis  = m_wait_bits;
          m_wait = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (!m_valid && m_n > 0) m_vis = m_col;
      m_ready = DBUF ? !m_wait : !m_valid;
    end
  end

  task automatic chkv(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk3) begin
    chk1("model_pix_ready", pix_ready, m_ready);
    chk1("model_feat_valid", feat_valid, m_valid);
    chk1("model_frame_err", frame_err, m_err);
    chkv("model_features", input_features, m_vis);
    if (frame_err === 1'b1) err_pulses++;
  end

  task automatic push(input bit sof, input logic [7:0] d);
    int w = 0;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    while (!m_ready && w < 300) begin
      @(posedge clk3); #1;
      w++;
    end
    if (!m_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: pix_ready never expected high within %0d cycles", w);
    end
    @(posedge clk3); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic release_frame();
    feat_ready = 1'b1;
    @(posedge clk3); #1;
    feat_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_v;
    logic [N-1:0] f1;
    logic [7:0]   d;

    reset2 = 1'b0;
    repeat (2) @(posedge clk3);
    #1;
    chk1("reset_pix_ready", pix_ready, 1'b0);
    chk1("reset_feat_valid", feat_valid, 1'b0);
    chkv("reset_features", input_features, '0);
    reset2 = 1'b1;
    @(posedge clk3); #1;
    chk1("ready_after_release", pix_ready, 1'b1);

    // Alternating frame, consumer always ready.
    feat_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      push(i == 0, (i % 2 == 0) ? 8'd200 : 8'd50);
      if (i == int'(N) - 2) chk1("alt_no_valid_early", feat_valid, 1'b0);
    end
    exp_v = {1'b1, {30{4'h5}}};
    chk1("alt_valid", feat_valid, 1'b1);
    chkv("alt_pattern", input_features, exp_v);
    @(posedge clk3); #1;
    chk1("alt_valid_drop", feat_valid, 1'b0);
    chk1("alt_ready_back", pix_ready, 1'b1);
    chkv("alt_bits_kept", input_features, exp_v);
    feat_ready = 1'b0;

    // Threshold boundary.
    push(1'b1, 8'd127);
    push(1'b0, 8'd128);
    push(1'b0, 8'd255);
    push(1'b0, 8'd0);
    for (int i = 4; i < int'(N); i++) push(1'b0, 8'd0);
    chkv("thresh_low4", N'(input_features[3:0]), N'(4'b0110));
    exp_v = '0; exp_v[1] = 1'b1; exp_v[2] = 1'b1;
    chkv("thresh_full", input_features, exp_v);
    release_frame();
    chk1("thresh_released", feat_valid, 1'b0);

    // Restart via sof at index 60.
    err_pulses = 0;
    for (int i = 0; i < 60; i++) push(i == 0, 8'd255);
    chk1("no_err_before_restart", frame_err, 1'b0);
    push(1'b1, 8'd255);
    chk1("restart_err", frame_err, 1'b1);
    exp_v = '0; exp_v[0] = 1'b1;
    chkv("restart_cleared", input_features, exp_v);
    for (int i = 1; i < int'(N); i++) begin
      push(1'b0, 8'd0);
      if (i == int'(N) - 2) chk1("restart_no_valid_early", feat_valid, 1'b0);
    end
    chkv("restart_err_count", N'(err_pulses), N'(1));
    chk1("restart_valid", feat_valid, 1'b1);
    chkv("restart_vec", input_features, exp_v);

    // Consumer stalls for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk3); #1;
      chk1("hold_valid", feat_valid, 1'b1);
      chkv("hold_vec", input_features, exp_v);
`ifndef NN1_FEAT_DOUBLE_BUF_EN
      chk1("hold_ready_low", pix_ready, 1'b0);
`endif
    end
    release_frame();
    chk1("hold_released", feat_valid, 1'b0);

    // Asynchronous reset at index 80.
    for (int i = 0; i < 80; i++) push(i == 0, 8'($urandom));
    #2;
    reset2 = 1'b0;
    #1;
    chk1("async_pix_ready", pix_ready, 1'b0);
    chk1("async_feat_valid", feat_valid, 1'b0);
    chk1("async_frame_err", frame_err, 1'b0);
    chkv("async_features", input_features, '0);
    @(posedge clk3); #1;
    reset2 = 1'b1;
    @(posedge clk3); #1;
    exp_v = '0;
    for (int i = 0; i < int'(N); i++) begin
      d = 8'($urandom);
      exp_v[i] = (d >= 8'd128);
      push(i == 0, d);
    end
    chk1("post_reset_valid", feat_valid, 1'b1);
    chkv("post_reset_vec", input_features, exp_v);
    release_frame();

`ifdef NN1_FEAT_DOUBLE_BUF_EN
    // Two back-to-back frames with the consumer stalled.
    f1 = '0;
    for (int i = 0; i < int'(N); i++) begin
      d = 8'($urandom);
      f1[i] = (d >= 8'd128);
      push(i == 0, d);
    end
    chk1("db_f1_valid", feat_valid, 1'b1);
    exp_v = '0;
    for (int i = 0; i < int'(N); i++) begin
      d = 8'($urandom);
      exp_v[i] = (d >= 8'd128);
      push(i == 0, d);
    end
    chk1("db_ready_drop", pix_ready, 1'b0);
    chkv("db_out_f1", input_features, f1);
    release_frame();
    chk1("db_swap_valid", feat_valid, 1'b1);
    chkv("db_out_f2", input_features, exp_v);
    release_frame();
    chk1("db_final_release", feat_valid, 1'b0);
`else
    f1 = '0;
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      pix_valid  = ($urandom_range(9) < 7);
      pix_sof    = (m_n == 0) ? ($urandom_range(19) == 0) : ($urandom_range(399) == 0);
      pix_data   = 8'($urandom);
      feat_ready = ($urandom_range(3) == 0);
      @(posedge clk3); #1;
    end
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    feat_ready = 1'b0;
    repeat (3) @(posedge clk3);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
